// File: rtl/hex_page_scroller.sv
// Holds a captured wide word and presents one 32-bit page of it to eight hex decoders.
// Pages advance on a debounced active-low button press or on an optional auto-scroll timer.
module hex_page_scroller #(
  parameter  int WORD_W      = 128,
  parameter  int DB_CYCLES   = 500000,
  parameter  int AUTO_CYCLES = 50000000,
  localparam int PAGES       = WORD_W / 32,
  localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] Data_In,
  input  logic              Load,
  input  logic              Next_Key,
  input  logic              Auto_En,
  output logic [31:0]       Nibbles,
  output logic [PAGE_W-1:0] Page,
  output logic              Valid
);

  localparam int DB_W   = (DB_CYCLES > 1)   ? $clog2(DB_CYCLES)   : 1;
  localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  logic [WORD_W-1:0] hold;
  logic              key_meta;
  logic              key_s;
  logic              key_stable;
  logic              key_stable_d;
  logic [DB_W-1:0]   db_cnt;
  logic [AUTO_W-1:0] auto_cnt;
  logic              press;
  logic              tick;
  logic [31:0]       page_sel;

  // Button: two-flop synchronizer, then accept a level only after it has been stable long enough.
  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_meta     <= 1'b1;
      key_s        <= 1'b1;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      db_cnt       <= '0;
    end else begin
      key_meta     <= Next_Key;
      key_s        <= key_meta;
      key_stable_d <= key_stable;
      if (key_s == key_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        key_stable <= key_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Only the released-to-pressed transition of the accepted level steps the page.
  assign press = key_stable_d & ~key_stable;
  assign tick  = Auto_En && (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));

  // A manual step restarts the auto interval so the next timed step is a full period away.
  always_ff @(posedge Clk) begin
    if (Reset || !Auto_En || press || tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    page_sel = '0;
    for (int i = 0; i < PAGES; i++) begin
      if (Page == PAGE_W'(i)) page_sel = hold[32*i +: 32];
    end
  end

  // Coincident press and tick still advance exactly one page.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold    <= '0;
      Valid   <= 1'b0;
      Page    <= '0;
      Nibbles <= '0;
    end else begin
      if (Load) begin
        hold  <= Data_In;
        Valid <= 1'b1;
      end
      if (press || tick) begin
        Page <= (Page == PAGE_W'(PAGES - 1)) ? '0 : Page + PAGE_W'(1);
      end
      Nibbles <= page_sel;
    end
  end

endmodule

// File: tb/tb_hex_page_scroller.sv
// Bench for hex_page_scroller: directed scenarios with fixed expectations, then random
// traffic compared cycle by cycle against a behavioural model of the scrolling rules.
module tb_hex_page_scroller;

  localparam int WORD_W = 128;
  localparam int DB     = 4;
  localparam int AUTO   = 10;
  localparam int PAGES  = WORD_W / 32;
  localparam logic [127:0] KAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [WORD_W-1:0] Data_In = '0;
  logic              Load = 1'b0;
  logic              Next_Key = 1'b1;
  logic              Auto_En = 1'b0;
  logic [31:0]       Nibbles;
  logic [1:0]        Page;
  logic              Valid;

  int n_cmp = 0;
  int n_bad = 0;

  hex_page_scroller #(
    .WORD_W(WORD_W),
    .DB_CYCLES(DB),
    .AUTO_CYCLES(AUTO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Data_In(Data_In),
    .Load(Load),
    .Next_Key(Next_Key),
    .Auto_En(Auto_En),
    .Nibbles(Nibbles),
    .Page(Page),
    .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: synced key as a two-deep queue, debounce as a run length of
  // disagreeing cycles, auto timer as cycles elapsed since the last restart.
  logic [127:0] m_hold = '0;
  logic [31:0]  m_nib = '0;
  bit           m_valid = 0;
  int           m_page = 0;
  bit           m_sync[$] = '{1'b1, 1'b1};
  bit           m_stable = 1;
  int           m_run = 0;
  bit           m_press = 0;
  int           m_elapsed = 0;

  task automatic model_step();
    bit key_s;
    bit step_manual;
    bit step_auto;
    if (Reset) begin
      m_hold = '0; m_nib = '0; m_valid = 0; m_page = 0;
      m_sync = '{1'b1, 1'b1}; m_stable = 1; m_run = 0; m_press = 0; m_elapsed = 0;
      return;
    end
    step_manual = m_press;
    step_auto   = Auto_En && (m_elapsed == AUTO - 1);
    m_nib = m_hold[32*m_page +: 32];
    key_s = m_sync[0];
    m_press = 0;
    if (key_s != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = key_s;
        m_run    = 0;
        m_press  = !key_s;
      end
    end else begin
      m_run = 0;
    end
    m_elapsed = (!Auto_En || step_manual || step_auto) ? 0 : m_elapsed + 1;
    if (step_manual || step_auto) m_page = (m_page + 1) % PAGES;
    if (Load) begin
      m_hold  = Data_In;
      m_valid = 1;
    end
    void'(m_sync.pop_front());
    m_sync.push_back(Next_Key);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  task automatic press_release();
    Next_Key = 1'b0;
    repeat (8) tick();
    Next_Key = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL reset_page: got %0d want 0", Page); end
    n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", Valid); end
    n_cmp++; if (Nibbles !== 32'h0) begin n_bad++; $display("FAIL reset_nibbles: got %h want 0", Nibbles); end
  endtask

  task automatic test_load();
    Data_In = KAT;
    Load = 1'b1;
    tick();
    Load = 1'b0;
    n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL load_valid: got %b want 1", Valid); end
    tick();
    n_cmp++; if (Nibbles !== 32'h7654_3210) begin n_bad++; $display("FAIL load_nibbles: got %h want 76543210", Nibbles); end
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL load_page: got %0d want 0", Page); end
  endtask

  task automatic test_press_hold();
    Next_Key = 1'b0;
    repeat (6) tick();
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL press_early: got %0d want 0", Page); end
    tick();
    n_cmp++; if (Page !== 2'd1) begin n_bad++; $display("FAIL press_step: got %0d want 1", Page); end
    tick();
    n_cmp++; if (Nibbles !== 32'hFEDC_BA98) begin n_bad++; $display("FAIL press_nibbles: got %h want fedcba98", Nibbles); end
    Next_Key = 1'b1;
    repeat (12) tick();
    n_cmp++; if (Page !== 2'd1) begin n_bad++; $display("FAIL release_no_step: got %0d want 1", Page); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      Next_Key = ((i / 2) % 2) != 0;
      tick();
    end
    Next_Key = 1'b1;
    repeat (12) tick();
    n_cmp++; if (Page !== 2'd1) begin n_bad++; $display("FAIL bounce_no_step: got %0d want 1", Page); end
  endtask

  task automatic test_wrap();
    int exp_seq[4] = '{1, 2, 3, 0};
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Data_In = KAT;
    Load = 1'b1;
    tick();
    Load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      press_release();
      n_cmp++;
      if (Page !== exp_seq[k][1:0]) begin
        n_bad++; $display("FAIL wrap_press%0d: got %0d want %0d", k + 1, Page, exp_seq[k]);
      end
    end
    n_cmp++; if (Nibbles !== 32'h7654_3210) begin n_bad++; $display("FAIL wrap_nibbles: got %h want 76543210", Nibbles); end
  endtask

  task automatic test_auto();
    Auto_En = 1'b1;
    repeat (9) tick();
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL auto_before1: got %0d want 0", Page); end
    tick();
    n_cmp++; if (Page !== 2'd1) begin n_bad++; $display("FAIL auto_step1: got %0d want 1", Page); end
    repeat (9) tick();
    n_cmp++; if (Page !== 2'd1) begin n_bad++; $display("FAIL auto_before2: got %0d want 1", Page); end
    tick();
    n_cmp++; if (Page !== 2'd2) begin n_bad++; $display("FAIL auto_step2: got %0d want 2", Page); end
    // Drop the key so its press event lands on the same cycle as the next tick.
    repeat (3) tick();
    Next_Key = 1'b0;
    repeat (6) tick();
    n_cmp++; if (Page !== 2'd2) begin n_bad++; $display("FAIL align_before: got %0d want 2", Page); end
    tick();
    n_cmp++; if (Page !== 2'd3) begin n_bad++; $display("FAIL align_single: got %0d want 3", Page); end
    Next_Key = 1'b1;
    repeat (9) tick();
    n_cmp++; if (Page !== 2'd3) begin n_bad++; $display("FAIL align_hold: got %0d want 3", Page); end
    tick();
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL align_next: got %0d want 0", Page); end
    Auto_En = 1'b0;
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    press_release();
    press_release();
    n_cmp++; if (Page !== 2'd2) begin n_bad++; $display("FAIL novalid_page: got %0d want 2", Page); end
    n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL novalid_valid: got %b want 0", Valid); end
    n_cmp++; if (Nibbles !== 32'h0) begin n_bad++; $display("FAIL novalid_nibbles: got %h want 0", Nibbles); end
    Data_In = KAT;
    Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    n_cmp++; if (Nibbles !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL page2_nibbles: got %h want 89abcdef", Nibbles); end
    Next_Key = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    Next_Key = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL midreset_page: got %0d want 0", Page); end
    n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", Valid); end
    n_cmp++; if (Nibbles !== 32'h0) begin n_bad++; $display("FAIL midreset_nibbles: got %h want 0", Nibbles); end
    repeat (12) tick();
    n_cmp++; if (Page !== 2'd0) begin n_bad++; $display("FAIL midreset_spurious: got %0d want 0", Page); end
  endtask

  task automatic test_random();
    int hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        Next_Key  = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 9);
      end
      hold_left--;
      if ((i % 37) == 0) Auto_En = 1'($urandom_range(0, 1));
      Load    = ($urandom_range(0, 7) == 0);
      Data_In = {$urandom, $urandom, $urandom, $urandom};
      Reset   = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++; if (Page !== m_page[1:0]) begin n_bad++; $display("FAIL rand_page@%0d: got %0d want %0d", i, Page, m_page); end
      n_cmp++; if (Valid !== m_valid) begin n_bad++; $display("FAIL rand_valid@%0d: got %b want %b", i, Valid, m_valid); end
      n_cmp++; if (Nibbles !== m_nib) begin n_bad++; $display("FAIL rand_nibbles@%0d: got %h want %h", i, Nibbles, m_nib); end
    end
    Reset = 1'b0;
    Load = 1'b0;
    Auto_En = 1'b0;
    Next_Key = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_press_hold();
    test_bounce();
    test_wrap();
    test_auto();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_page_scroller.md
Name: hex_page_scroller

Overview:
- Upstream feeder for the board's bank of eight 4-bit-to-7-segment hex decoders.
- Captures a wide data word, such as an AES state, key or ciphertext, into a holding register.
- Presents one 32-bit page of that word at a time as eight nibbles, one nibble per decoder.
- Pages advance on a debounced push-button press or on an optional auto-scroll timer.

Parameters:
- WORD_W, 128, captured word width; must be a multiple of 32.
- PAGES, WORD_W/32, derived page count; the page index is clog2(PAGES) bits wide, minimum 1.
- DB_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted.
- AUTO_CYCLES, 50000000, cycles per automatic page step when Auto_En=1.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous, active-high.
- Data_In, in, WORD_W, word to capture.
- Load, in, 1, capture strobe; sampled on each rising Clk edge.
- Next_Key, in, 1, raw push button, active-low, asynchronous to Clk, bouncing.
- Auto_En, in, 1, level; enables timed scrolling.
- Nibbles, out, 32, eight nibbles for the decoders; Nibbles[3:0] feeds the rightmost digit.
- Page, out, clog2(PAGES), current page index.
- Valid, out, 1, high once at least one capture has occurred since reset.

Behaviour:
- Reset, synchronous, one cycle: holding register=0, Page=0, Valid=0, Nibbles=0, auto counter=0, debounce counter=0, synchronizer and stable button state=1 (released). Reset asserted mid-debounce or mid-count discards all progress.
- Capture: if Load=1 at an edge, the holding register takes Data_In and Valid goes to 1 at that same edge. Page is not changed by Load. Load held high recaptures every cycle.
- Output selection: Nibbles = holding register bits [32*Page+31 : 32*Page].
  - Nibbles is registered and updates one cycle after the holding register or Page changes.
  - Latency from Load to Nibbles is 2 cycles.
- Button path:
  - Next_Key passes through a 2-flop synchronizer, giving key_s.
  - While key_s differs from the stable state, the debounce counter increments. When it reaches DB_CYCLES-1, the stable state takes key_s and the counter clears.
  - Any cycle with key_s equal to the stable state clears the counter, so bounces restart the count.
  - A press event is a stable-state transition from 1 to 0. It is a single-cycle internal pulse. Release produces no event.
- Auto timer:
  - While Auto_En=1, the counter counts 0..AUTO_CYCLES-1. A tick is issued on the cycle the counter equals AUTO_CYCLES-1, and the counter wraps to 0 on that cycle.
  - Auto_En=0 holds the counter at 0.
  - A press event also clears the auto counter, so the full interval restarts after a manual step.
- Page advance:
  - Page increments on the edge after a press event or an auto tick.
  - Page wraps from PAGES-1 to 0.
  - A press event and an auto tick in the same cycle advance Page by exactly 1.
- Valid=0: page stepping still operates and Nibbles shows the zeroed holding register.
- Load coincident with a page advance: both take effect at the same edge. On the following cycle Nibbles shows the new data at the new page.
- No combinational path from any input to any output.

Test Plan (DB_CYCLES=4, AUTO_CYCLES=10, WORD_W=128):
- Reset then Load with Data_In=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> Valid=1 one cycle after Load. Two cycles after Load: Nibbles=0x76543210 and Page=0.
- Hold Next_Key=0 for 8 cycles, then release -> Page=1 exactly once, 2+4+1 cycles after the falling edge, and Nibbles=0xFEDCBA98. Release causes no advance.
- Toggle Next_Key 0/1 every 2 cycles for 20 cycles, then hold at 1 -> Page unchanged.
- Press 4 clean times from Page=0 -> Page sequence 1,2,3,0. After the 4th press, Nibbles=0x76543210.
- Auto_En=1 from Page=0 -> Page steps every 10 cycles. Align a press event with a tick -> single increment, and the next auto step comes 10 cycles after the press.
- Reset asserted while the debounce count is at 2 and Page=2 -> Page=0, Valid=0, Nibbles=0. No spurious advance after Reset deasserts with Next_Key=1.
